code_conv_pipe: RTL
===================

Name: code_conv_pipe

Overview:
- Pipelined, parametrised number-code converter for the SPI execution unit.
- Converts one BITS-wide operand per cycle between U1 (ones' complement), U2 (two's complement) and SM (sign-magnitude), selected per transaction by a mode field.
- Uses valid/ready handshakes on input and output and flags non-representable and negative-zero cases.
- Keeps a saturating count of overflow events, readable by the control logic.

Parameters:
- BITS, 8, operand/result width; minimum 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  input operand valid.
- o_ready  output  1  block can accept an operand this cycle.
- i_argA  input  BITS  operand.
- i_mode  input  2  00 U1->U2, 01 U2->U1, 10 SM->U2, 11 U2->SM.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  BITS  converted value.
- o_ovf  output  1  input value not representable in target code.
- o_negzero  output  1  input was a negative zero (U1 all-ones, or SM 10..0).
- i_clr  input  1  synchronous clear of overflow counter.
- o_ovf_cnt  output  CNT_W  saturating count of accepted transactions with ovf=1.

Behaviour:
- Reset (i_rstn=0, async):
  - o_valid=0, o_result=0, o_ovf=0, o_negzero=0, o_ovf_cnt=0.
  - Stage-1 valid cleared; in-flight data discarded.
  - o_ready=1 from the first cycle after release.
- Pipeline:
  - S1 registers i_argA and i_mode on the input handshake (i_valid && o_ready).
  - S2 computes and registers o_result and flags.
  - Latency is exactly 2 cycles from input handshake to o_valid when unstalled; throughput 1 per cycle.
- Flow control:
  - S2 loads when empty or when its result is consumed (o_valid && i_ready).
  - S1 advances into S2 under the same condition.
  - o_ready = !s1_valid || S2 can load. Combinational; does not depend on i_valid.
  - Simultaneous input and output handshakes in one cycle are supported with no bubble.
  - Capacity is 2 entries. Ordering is strictly preserved.
  - While o_valid=1 and i_ready=0, o_result, o_ovf and o_negzero hold stable.
- Arithmetic (msb = sign; positive inputs pass unchanged in all modes; no flags):
  - U1->U2, msb=1: result = a+1 mod 2^BITS. Input all-ones gives 0 with negzero=1. ovf is never set.
  - U2->U1, msb=1: result = a-1. Input 10..0 sets ovf=1; result is 01..1 (wrap, default).
  - SM->U2, msb=1: result = 0 - {0,a[BITS-2:0]} mod 2^BITS. Input 10..0 gives 0 with negzero=1.
  - U2->SM, msb=1: result = {1, (0-a)[BITS-2:0]}. Input 10..0 sets ovf=1; result is 10..0 (wrap, default).
  - U1->U2 and SM->U2 are never ovf. U2->U1 and U2->SM are never negzero.
- Counter:
  - Increments by 1 when a result with ovf=1 is loaded into S2.
  - Holds at 2^CNT_W-1; never wraps.
  - i_clr forces it to 0. If i_clr coincides with an increment, clear wins.
- i_mode is sampled only at the input handshake. Changing it while a transaction is in flight does not affect that transaction.

Optional Feature:
- Macro: CODE_CONV_SAT_EN.
- Defined: ovf cases saturate to the most negative representable target value.
  - U2->U1 of 10..0 gives 10..0 (U1 -(2^(BITS-1)-1)).
  - U2->SM of 10..0 gives 11..1.
  - o_ovf is still asserted and counted.
- Undefined: wrap results as stated above.
- All other behaviour is identical either way.

Test Plan:
- BITS=8, unstalled:
  - mode 00, 0xFE -> 0xFF after 2 cycles.
  - mode 00, 0xFF -> 0x00, negzero=1.
  - mode 00, 0x05 -> 0x05, no flags.
- mode 10, 0x85 -> 0xFB. mode 11, 0xFB -> 0x85. mode 10, 0x80 -> 0x00, negzero=1.
- Overflow cases:
  - mode 01, 0x80 -> ovf=1, result 0x7F (no macro) / 0x80 (CODE_CONV_SAT_EN).
  - mode 11, 0x80 -> ovf=1, result 0x80 (no macro) / 0xFF (CODE_CONV_SAT_EN).
  - After both, o_ovf_cnt=2.
- Backpressure:
  - Hold i_ready=0 and offer 3 operands back to back. o_ready drops after 2 are accepted; the third is held at input.
  - Raise i_ready: results appear in order on 3 consecutive cycles, and the third operand is accepted in the release cycle.
- Counter: CNT_W=2, 5 ovf transactions -> o_ovf_cnt=3. Pulse i_clr in the cycle of a 6th ovf -> 0.
- Reset: assert i_rstn=0 with 2 entries in flight -> o_valid=0, o_ovf_cnt=0 immediately. After release no stale result appears and o_ready=1.

Source files
------------

// File: rtl/code_conv_pipe.sv
// code_conv_pipe
//   Two-stage pipelined converter between U1 (ones' complement), U2 (two's
//   complement) and SM (sign-magnitude) number codes, one operand per cycle.
//   S1 captures operand + mode on the input handshake; S2 holds the converted
//   result and flags until the consumer takes it. A saturating counter tracks
//   how many ovf results have entered S2.
//
//   Optional build macro: CODE_CONV_SAT_EN
//     defined   -> ovf cases saturate to the most negative target value
//     undefined -> ovf cases wrap (U2->U1 of 10..0 = 01..1, U2->SM = 10..0)
//
// Ports
//   i_clk, i_rstn        clock, async active-low reset
//   i_valid/o_ready      input handshake; i_argA operand, i_mode select
//                        (00 U1->U2, 01 U2->U1, 10 SM->U2, 11 U2->SM)
//   o_valid/i_ready      output handshake; o_result, o_ovf, o_negzero
//   i_clr                synchronous clear of the overflow counter
//   o_ovf_cnt            saturating count of ovf results
module code_conv_pipe #(
    parameter int BITS  = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BITS-1:0]  i_argA,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [BITS-1:0]  o_result,
    output logic             o_ovf,
    output logic             o_negzero,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    localparam logic [BITS-1:0]  MIN_V = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [BITS-1:0]  ONE_V = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: captured operand
    logic            s1_valid_q, s1_valid_d;
    logic [BITS-1:0] s1_a_q, s1_a_d;
    logic [1:0]      s1_mode_q, s1_mode_d;

    // Stage 2: converted result
    logic            s2_valid_q, s2_valid_d;
    logic [BITS-1:0] res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            negzero_q, negzero_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            s2_load;
    logic            in_hs;
    logic [BITS-1:0] res_c;
    logic            ovf_c;
    logic            negzero_c;
    logic [BITS-1:0] neg_a;
    logic [BITS-1:0] mag_a;

    // S2 can take a new entry when empty or when its result leaves this cycle.
    assign s2_load = !s2_valid_q || i_ready;
    assign o_ready = !s1_valid_q || s2_load;
    assign in_hs   = i_valid && o_ready;

    // Conversion of the S1 operand. Non-negative inputs pass unchanged.
    always_comb begin
        res_c     = s1_a_q;
        ovf_c     = 1'b0;
        negzero_c = 1'b0;
        neg_a     = '0 - s1_a_q;
        mag_a     = {1'b0, s1_a_q[BITS-2:0]};
        if (s1_a_q[BITS-1]) begin
            case (s1_mode_q)
                2'b00: begin // U1 -> U2
                    res_c     = s1_a_q + ONE_V;
                    negzero_c = (s1_a_q == '1);
                end
                2'b01: begin // U2 -> U1
                    res_c = s1_a_q - ONE_V;
                    ovf_c = (s1_a_q == MIN_V);
`ifdef CODE_CONV_SAT_EN
                    if (ovf_c) res_c = MIN_V;
`endif
                end
                2'b10: begin // SM -> U2
                    res_c     = '0 - mag_a;
                    negzero_c = (s1_a_q == MIN_V);
                end
                default: begin // U2 -> SM
                    res_c = {1'b1, neg_a[BITS-2:0]};
                    ovf_c = (s1_a_q == MIN_V);
`ifdef CODE_CONV_SAT_EN
                    if (ovf_c) res_c = '1;
`endif
                end
            endcase
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        negzero_d  = negzero_q;
        cnt_d      = cnt_q;

        // S1 empties when its entry moves on; refilled by a new handshake.
        if (s2_load) s1_valid_d = 1'b0;
        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_a_d     = i_argA;
            s1_mode_d  = i_mode;
        end

        // Result fields only change when a real entry arrives, so they hold
        // steady under backpressure and after draining.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d     = res_c;
                ovf_d     = ovf_c;
                negzero_d = negzero_c;
            end
        end

        if (i_clr)
            cnt_d = '0;
        else if (s2_load && s1_valid_q && ovf_c && (cnt_q != '1))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            negzero_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            negzero_q  <= negzero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_result  = res_q;
    assign o_ovf     = ovf_q;
    assign o_negzero = negzero_q;
    assign o_ovf_cnt = cnt_q;

endmodule
